pattern_hflipper: RTL and testbench
===================================

Name: pattern_hflipper

Overview:
- Horizontal-flip stage for one background/sprite pattern line: 8 pixels × 2 bits per pixel, packed into 16 bits.
- Optionally reverses pixel order while keeping the bit order inside each pixel.
- Sits between the PMB line fetch and the background scanline memory (BSM), one instance per nametable column.
- Output is registered (1-cycle latency) with a valid flag, so it can be used in the pipelined GPU variant.

Parameters:
- PIXELS, 8, pixels per pattern line; must be ≥1.
- BPP, 2, bits per pixel; must be ≥1.
- LW = PIXELS*BPP (localparam), line width, 16 at defaults.

Ports:
- clk  in  1  pixel clock (12.5875 MHz system clock).
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- line_in  in  LW  pattern line.
  - Pixel 0 (leftmost on screen) is in bits [LW-1 -: BPP].
  - Pixel PIXELS-1 is in bits [BPP-1:0].
- hflip  in  1  1 = mirror the line horizontally; 0 = pass through.
- in_valid  in  1  line_in/hflip are valid this cycle.
- line_out  out  LW  registered result.
- out_valid  out  1  registered in_valid.

Behaviour:
- Reset (rst = 0, asynchronous, no clock needed):
  - line_out = 0 and out_valid = 0 immediately.
  - Both outputs hold those values while rst stays low.
- Reset release:
  - Deassertion is sampled at the next rising clk edge.
  - Normal capture starts on the first rising edge with rst = 1.
- Flip function (combinational, f(line, hflip)):
  - hflip = 0: f = line, bit-exact.
  - hflip = 1: for each i in 0..PIXELS-1, output pixel i = input pixel PIXELS-1-i. Each pixel's BPP-bit field is copied unchanged (no bit reversal inside a pixel).
  - At defaults: out[15:14] = in[1:0], out[13:12] = in[3:2], …, out[1:0] = in[15:14].
- Pipeline, on each rising clk edge with rst = 1:
  - out_valid <= in_valid.
  - If in_valid = 1: line_out <= f(line_in, hflip).
  - If in_valid = 0: line_out holds its previous value (no capture).
- Latency and throughput:
  - Exactly 1 cycle from input to output.
  - Full throughput: one line per cycle, no stalls, no backpressure.
- hflip is sampled per cycle together with line_in; it has no sticky state.
- Applying the flip twice gives back the original line.
- Reset during a transfer:
  - An in-flight result is discarded: out_valid = 0, line_out = 0.
  - After release, the first captured line appears one cycle after its in_valid.
- No X propagation from an idle input: line_out changes only on valid captures or on reset.

Test Plan:
- Reset:
  - Drive rst = 0 mid-cycle with in_valid = 1 and line_in = 16'hFFFF → line_out = 0 and out_valid = 0 immediately, without waiting for a clk edge.
  - Release rst, then present 16'h1234 with hflip = 0 → line_out = 16'h1234 one cycle later.
- Pass-through:
  - hflip = 0, line_in = 16'b00_01_00_10_00_11_00_01 (16'h1231), in_valid = 1 → next cycle line_out = 16'h1231, out_valid = 1.
- Flip:
  - hflip = 1, line_in = 16'b00_01_00_10_00_11_00_01 → line_out = 16'b01_00_11_00_10_00_01_00 (16'h4C84).
  - hflip = 1, line_in = 16'b11_00_11_00_11_00_11_00 (16'hCCCC) → 16'b00_11_00_11_00_11_00_11 (16'h3333).
- Symmetric pattern:
  - hflip = 1, line_in = 16'b00_01_10_11_11_10_01_00 (16'h1BE4) → line_out = 16'h1BE4 (palindrome unchanged).
- Back-to-back and hold:
  - Stream 16'h0001 (flip), 16'h8000 (flip), 16'h00FF (no flip) on consecutive cycles → outputs 16'h4000, 16'h0002, 16'h00FF on consecutive cycles, out_valid high for 3 cycles.
  - Then in_valid = 0 → out_valid = 0 and line_out holds 16'h00FF.
- Parameter sweep:
  - PIXELS = 4, BPP = 4, hflip = 1, line_in = 16'h1234 → 16'h4321.
  - Random lines compared against the reference model for both hflip values.
  - flip(flip(x)) = x checked over 1000 random vectors.

Source files
------------

// File: rtl/pattern_hflipper_if.sv
// rtl/pattern_hflipper_if.sv - pattern line stream between line fetch and the flip stage
// The master drives one line per cycle. The slave returns the registered result.
interface pattern_hflipper_if #(
  parameter int LW = 16
) ();
  logic [LW-1:0] line_in;
  logic          hflip;
  logic          in_valid;
  logic [LW-1:0] line_out;
  logic          out_valid;

  modport master (
    output line_in,
    output hflip,
    output in_valid,
    input  line_out,
    input  out_valid
  );

  modport slave (
    input  line_in,
    input  hflip,
    input  in_valid,
    output line_out,
    output out_valid
  );
endinterface

// File: rtl/pattern_hflipper.sv
// rtl/pattern_hflipper.sv - optional horizontal mirror of one packed pattern line, 1-cycle registered
// Pixel order is reversed while the bits within each pixel are kept as they are.
module pattern_hflipper #(
  parameter int PIXELS = 8,
  parameter int BPP    = 2
) (
  input  logic                clk,
  input  logic                rst,
  pattern_hflipper_if.slave   bus
);
  localparam int LW = PIXELS * BPP;

  logic [LW-1:0] w_flipped;
  logic [LW-1:0] w_next;
  logic [LW-1:0] r_line;
  logic          r_valid;

  // Output pixel i (counted from the MSB side) takes input pixel PIXELS-1-i.
  always_comb begin
    w_flipped = '0;
    for (int i = 0; i < PIXELS; i++) begin
      w_flipped[LW-1-i*BPP -: BPP] = bus.line_in[(i+1)*BPP-1 -: BPP];
    end
  end

  assign w_next = bus.hflip ? w_flipped : bus.line_in;

  // Idle cycles leave r_line untouched so undriven inputs never reach the BSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_line <= w_next;
      end
    end
  end

  assign bus.line_out  = r_line;
  assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_pattern_hflipper.sv
// tb/tb_pattern_hflipper.sv - directed and random checks of pattern_hflipper at 8x2 and 4x4
module tb_pattern_hflipper;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pattern_hflipper_if #(.LW(16)) bus8 ();
  pattern_hflipper_if #(.LW(16)) bus4 ();

  pattern_hflipper #(.PIXELS(8), .BPP(2)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  pattern_hflipper #(.PIXELS(4), .BPP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit b, counted from the LSB, belongs to pixel (pixels-1-b/bpp); mirror it bit by bit.
  function automatic logic [15:0] ref_flip(input logic [15:0] x, input int pixels, input int bpp);
    logic [15:0] y;
    y = '0;
    for (int b = 0; b < pixels * bpp; b++) begin
      y[(pixels - 1 - b / bpp) * bpp + (b % bpp)] = x[b];
    end
    return y;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [15:0] l, input logic f, input logic v);
    bus8.line_in  = l;
    bus8.hflip    = f;
    bus8.in_valid = v;
  endtask

  task automatic drive4(input logic [15:0] l, input logic f, input logic v);
    bus4.line_in  = l;
    bus4.hflip    = f;
    bus4.in_valid = v;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive8(16'h0000, 1'b0, 1'b0);
    drive4(16'h0000, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    drive8(16'hABCD, 1'b0, 1'b1);
    step();
    n_checks++;
    if (bus8.line_out !== 16'hABCD || bus8.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL preload: line_out=%h out_valid=%b, expected ABCD 1", bus8.line_out, bus8.out_valid);
    end
    drive8(16'hFFFF, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus8.line_out !== 16'h0000 || bus8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: line_out=%h out_valid=%b, expected 0000 0", bus8.line_out, bus8.out_valid);
    end
    n_checks++;
    if (bus4.line_out !== 16'h0000 || bus4.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_4x4: line_out=%h out_valid=%b, expected 0000 0", bus4.line_out, bus4.out_valid);
    end
    step();
    n_checks++;
    if (bus8.line_out !== 16'h0000 || bus8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: line_out=%h out_valid=%b, expected 0000 0", bus8.line_out, bus8.out_valid);
    end
    rst = 1'b1;
    drive8(16'h1234, 1'b0, 1'b1);
    step();
    n_checks++;
    if (bus8.line_out !== 16'h1234 || bus8.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: line_out=%h out_valid=%b, expected 1234 1", bus8.line_out, bus8.out_valid);
    end
  endtask

  task automatic test_pass_through();
    drive8(16'h1231, 1'b0, 1'b1);
    step();
    n_checks++;
    if (bus8.line_out !== 16'h1231 || bus8.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_through: line_out=%h out_valid=%b, expected 1231 1", bus8.line_out, bus8.out_valid);
    end
  endtask

  task automatic test_flip();
    drive8(16'h1231, 1'b1, 1'b1);
    step();
    n_checks++;
    if (bus8.line_out !== 16'h4C84 || bus8.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flip_1231: line_out=%h out_valid=%b, expected 4C84 1", bus8.line_out, bus8.out_valid);
    end
    drive8(16'hCCCC, 1'b1, 1'b1);
    step();
    n_checks++;
    if (bus8.line_out !== 16'h3333) begin
      n_fail++;
      $display("FAIL flip_cccc: line_out=%h, expected 3333", bus8.line_out);
    end
  endtask

  task automatic test_symmetric();
    drive8(16'h1BE4, 1'b1, 1'b1);
    step();
    n_checks++;
    if (bus8.line_out !== 16'h1BE4) begin
      n_fail++;
      $display("FAIL palindrome: line_out=%h, expected 1BE4", bus8.line_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins  [3];
    logic        flps [3];
    logic [15:0] exps [3];
    ins  = '{16'h0001, 16'h8000, 16'h00FF};
    flps = '{1'b1, 1'b1, 1'b0};
    exps = '{16'h4000, 16'h0002, 16'h00FF};
    for (int i = 0; i < 3; i++) begin
      drive8(ins[i], flps[i], 1'b1);
      step();
      n_checks++;
      if (bus8.line_out !== exps[i] || bus8.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: line_out=%h out_valid=%b, expected %h 1", i, bus8.line_out, bus8.out_valid, exps[i]);
      end
    end
    drive8('x, 1'bx, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (bus8.line_out !== 16'h00FF || bus8.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: line_out=%h out_valid=%b, expected 00FF 0", i, bus8.line_out, bus8.out_valid);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    drive8(16'h5555, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus8.line_out !== 16'h0000 || bus8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL in_flight_reset: line_out=%h out_valid=%b, expected 0000 0", bus8.line_out, bus8.out_valid);
    end
    step();
    rst = 1'b1;
    drive8(16'h0003, 1'b1, 1'b1);
    step();
    n_checks++;
    if (bus8.line_out !== 16'hC000 || bus8.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL after_in_flight: line_out=%h out_valid=%b, expected C000 1", bus8.line_out, bus8.out_valid);
    end
    drive8(16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_param_4x4();
    drive4(16'h1234, 1'b1, 1'b1);
    step();
    n_checks++;
    if (bus4.line_out !== 16'h4321 || bus4.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flip_4x4: line_out=%h out_valid=%b, expected 4321 1", bus4.line_out, bus4.out_valid);
    end
    drive4(16'h1234, 1'b0, 1'b1);
    step();
    n_checks++;
    if (bus4.line_out !== 16'h1234) begin
      n_fail++;
      $display("FAIL pass_4x4: line_out=%h, expected 1234", bus4.line_out);
    end
  endtask

  task automatic test_random();
    logic [15:0] x;
    logic [15:0] e8;
    logic [15:0] e4;
    logic        f;
    for (int i = 0; i < 100; i++) begin
      x = 16'($urandom);
      f = 1'(i % 2);
      e8 = f ? ref_flip(x, 8, 2) : x;
      e4 = f ? ref_flip(x, 4, 4) : x;
      drive8(x, f, 1'b1);
      drive4(x, f, 1'b1);
      step();
      n_checks++;
      if (bus8.line_out !== e8) begin
        n_fail++;
        $display("FAIL random_8x2: in=%h hflip=%b line_out=%h expected %h", x, f, bus8.line_out, e8);
      end
      n_checks++;
      if (bus4.line_out !== e4) begin
        n_fail++;
        $display("FAIL random_4x4: in=%h hflip=%b line_out=%h expected %h", x, f, bus4.line_out, e4);
      end
    end
    drive4(16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_double_flip();
    logic [15:0] x;
    logic [15:0] y;
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom);
      drive8(x, 1'b1, 1'b1);
      step();
      y = bus8.line_out;
      drive8(y, 1'b1, 1'b1);
      step();
      n_checks++;
      if (bus8.line_out !== x) begin
        n_fail++;
        $display("FAIL double_flip: x=%h once=%h twice=%h expected %h", x, y, bus8.line_out, x);
      end
    end
    drive8(16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_pass_through();
    test_flip();
    test_symmetric();
    test_back_to_back();
    test_reset_in_flight();
    test_param_4x4();
    test_random();
    test_double_flip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
